alu_iter: RTL and testbench

ALU_ITER -- requirements
Module: alu_iter

---
 rtl/alu_iter_pkg.sv | 37 +++
 rtl/alu_iter_dp.sv | 92 +++++++++
 rtl/alu_iter.sv | 105 ++++++++++
 tb/tb_alu_iter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_iter_pkg.sv
// Shared CPU definitions: ALUCtrl operation codes, iterative-ALU state encoding
// and small decode helpers used by both the FSM and the datapath.
package alu_iter_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SLLV = 4'b1010;
  localparam logic [3:0] ALU_SRLV = 4'b1011;
  localparam logic [3:0] ALU_MUL  = 4'b1100;

  // EXEC is the single evaluate cycle of one-cycle ops; DONE is the done_o cycle.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_MUL   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic is_supported(input logic [3:0] code);
    case (code)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT,
      ALU_SLL, ALU_SRL, ALU_SLLV, ALU_SRLV, ALU_MUL: is_supported = 1'b1;
      default:                                       is_supported = 1'b0;
    endcase
  endfunction

  function automatic logic is_left_shift(input logic [3:0] code);
    is_left_shift = (code == ALU_SLL) || (code == ALU_SLLV);
  endfunction

endpackage

// File: rtl/alu_iter_dp.sv
// Iterative ALU datapath: captured operands, shift register, MUL accumulator, step counter.
// res_o is the value the op will hold after the current step; last_o flags the final step.
module alu_iter_dp
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [4:0]       shamt_i,
  output logic             last_o,
  output logic             err_o,
  output logic [WIDTH-1:0] res_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [CW-1:0]    cnt_q;

  logic [4:0]       amt;
  logic [CW-1:0]    cnt_load;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] mul_acc;
  logic             slt;

  always_comb begin
    amt      = ((op_i == ALU_SLLV) || (op_i == ALU_SRLV)) ? src1_i[4:0] : shamt_i;
    cnt_load = '0;
    if (op_i == ALU_MUL) begin
      cnt_load = CW'(WIDTH);
    end else if ((op_i == ALU_SLL) || (op_i == ALU_SRL) ||
                 (op_i == ALU_SLLV) || (op_i == ALU_SRLV)) begin
      cnt_load = CW'(amt);
    end
  end

  assign shifted = is_left_shift(op_q) ? (b_q << 1) : (b_q >> 1);
  assign mul_acc = acc_q + (b_q[0] ? a_q : '0);
  assign slt     = $signed(a_q) < $signed(b_q);

  always_comb begin
    res_o = '0;
    case (op_q)
      ALU_AND:  res_o = a_q & b_q;
      ALU_OR:   res_o = a_q | b_q;
      ALU_ADD:  res_o = a_q + b_q;
      ALU_SUB:  res_o = a_q - b_q;
      ALU_SLT:  res_o = {{(WIDTH-1){1'b0}}, slt};
      // A zero-amount shift never enters the stepping loop and returns src2 untouched.
      ALU_SLL, ALU_SRL, ALU_SLLV, ALU_SRLV:
                res_o = (cnt_q == '0) ? b_q : shifted;
      ALU_MUL:  res_o = mul_acc;
      default:  res_o = '0;
    endcase
  end

  assign last_o = (cnt_q == CW'(1));
  assign err_o  = !is_supported(op_q);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q  <= ALU_AND;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      op_q  <= op_i;
      a_q   <= src1_i;
      b_q   <= src2_i;
      acc_q <= '0;
      cnt_q <= cnt_load;
    end else if (step_i) begin
      cnt_q <= cnt_q - CW'(1);
      if (op_q == ALU_MUL) begin
        acc_q <= mul_acc;
        a_q   <= a_q << 1;
        b_q   <= b_q >> 1;
      end else begin
        b_q <= shifted;
      end
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle ALU: logic/arith ops in 1 cycle, shifts in max(k,1), MUL in WIDTH cycles.
// start_i is ignored while busy_o; a start on the done_o cycle is accepted back-to-back.
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [4:0]       shamt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             err_o
);

  state_e           state_q, state_d, start_state;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, err_q;
  logic             load, step, finish;
  logic             dp_last, dp_err;
  logic [WIDTH-1:0] dp_res;

  always_comb begin
    start_state = ST_EXEC;
    if (ALUCtrl_i == ALU_MUL) begin
      start_state = ST_MUL;
    end else if (((ALUCtrl_i == ALU_SLL) || (ALUCtrl_i == ALU_SRL)) && (shamt_i != '0)) begin
      start_state = ST_SHIFT;
    end else if (((ALUCtrl_i == ALU_SLLV) || (ALUCtrl_i == ALU_SRLV)) && (src1_i[4:0] != '0)) begin
      start_state = ST_SHIFT;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = start_state;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        finish  = 1'b1;
        state_d = ST_DONE;
      end
      ST_SHIFT, ST_MUL: begin
        step = 1'b1;
        if (dp_last) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (finish) begin
        result_q <= dp_res;
        zero_q   <= (dp_res == '0);
        err_q    <= dp_err;
      end
    end
  end

  alu_iter_dp #(.WIDTH(WIDTH)) u_dp (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load),
    .step_i  (step),
    .op_i    (ALUCtrl_i),
    .src1_i  (src1_i),
    .src2_i  (src2_i),
    .shamt_i (shamt_i),
    .last_o  (dp_last),
    .err_o   (dp_err),
    .res_o   (dp_res)
  );

  assign busy_o   = (state_q == ST_EXEC) || (state_q == ST_SHIFT) || (state_q == ST_MUL);
  assign done_o   = (state_q == ST_DONE);
  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed + randomized bench for alu_iter against an arithmetic reference model.
module tb_alu_iter;
  import alu_iter_pkg::*;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         start_i = 1'b0;
  logic [3:0]   ALUCtrl_i = '0;
  logic [W-1:0] src1_i = '0;
  logic [W-1:0] src2_i = '0;
  logic [4:0]   shamt_i = '0;
  logic         busy_o, done_o, zero_o, err_o;
  logic [W-1:0] result_o;

  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] prev_res = '0;

  alu_iter #(.WIDTH(W)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .ALUCtrl_i(ALUCtrl_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .shamt_i  (shamt_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .zero_o   (zero_o),
    .err_o    (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour straight from the operation definitions.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [4:0] sh, output logic [W-1:0] r, output logic e,
                                output int lat);
    logic [63:0] prod;
    logic [4:0]  k;
    e   = 1'b0;
    lat = 1;
    r   = '0;
    k   = a[4:0];
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: begin r = b << sh; lat = (sh == 0) ? 1 : int'(sh); end
      4'b1001: begin r = b >> sh; lat = (sh == 0) ? 1 : int'(sh); end
      4'b1010: begin r = b << k;  lat = (k == 0) ? 1 : int'(k);  end
      4'b1011: begin r = b >> k;  lat = (k == 0) ? 1 : int'(k);  end
      4'b1100: begin prod = {32'd0, a} * {32'd0, b}; r = prod[31:0]; lat = W; end
      default: begin r = '0; e = 1'b1; end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done_o is first seen.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] sh, input bit noise);
    logic [W-1:0] er;
    logic         ee;
    int           el;
    int           lat;
    bit           busy_ok;
    bit           hold_ok;
    model(op, a, b, sh, er, ee, el);
    ALUCtrl_i = op; src1_i = a; src2_i = b; shamt_i = sh; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    src1_i = $urandom; src2_i = $urandom; shamt_i = 5'($urandom); ALUCtrl_i = 4'($urandom);
    lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (!done_o && lat < 200) begin
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      if (result_o !== prev_res) hold_ok = 1'b0;
      if (noise) begin
        start_i = 1'($urandom_range(0, 1));
        ALUCtrl_i = 4'($urandom); src1_i = $urandom; src2_i = $urandom;
      end
      @(negedge clk_i);
      lat++;
    end
    start_i = 1'b0;
    check({nm, " latency"}, 64'(lat), 64'(el));
    check({nm, " busy_during"}, {63'd0, busy_ok}, 64'd1);
    check({nm, " result_hold"}, {63'd0, hold_ok}, 64'd1);
    check({nm, " busy_at_done"}, {63'd0, busy_o}, 64'd0);
    check({nm, " result"}, {32'd0, result_o}, {32'd0, er});
    check({nm, " zero"}, {63'd0, zero_o}, {63'd0, (er == '0)});
    check({nm, " err"}, {63'd0, err_o}, {63'd0, ee});
    prev_res = er;
  endtask

  task automatic idle_after(input string nm);
    @(negedge clk_i);
    check({nm, " done_width"}, {63'd0, done_o}, 64'd0);
    check({nm, " idle_busy"}, {63'd0, busy_o}, 64'd0);
    check({nm, " idle_result"}, {32'd0, result_o}, {32'd0, prev_res});
  endtask

  initial begin
    logic [3:0] ops_tbl [10];
    bit         quiet;
    ops_tbl = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100};

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst busy", {63'd0, busy_o}, 64'd0);
    check("rst done", {63'd0, done_o}, 64'd0);
    check("rst result", {32'd0, result_o}, 64'd0);
    check("rst zero", {63'd0, zero_o}, 64'd0);
    check("rst err", {63'd0, err_o}, 64'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Directed corner cases
    run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b0);
    check("add_ovf value", {32'd0, result_o}, 64'h8000_0000);
    idle_after("add_ovf");
    run_op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b0);
    check("slt_neg value", {32'd0, result_o}, 64'd1);
    idle_after("slt_neg");
    run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 5'd0, 1'b0);
    check("sub_zero flag", {63'd0, zero_o}, 64'd1);
    idle_after("sub_zero");
    run_op("srl31", 4'b1001, 32'h0, 32'h8000_0000, 5'd31, 1'b0);
    check("srl31 value", {32'd0, result_o}, 64'd1);
    idle_after("srl31");
    run_op("sllv0", 4'b1010, 32'h0000_0020, 32'hDEAD_BEEF, 5'd3, 1'b0);
    check("sllv0 value", {32'd0, result_o}, 64'hDEAD_BEEF);
    idle_after("sllv0");
    run_op("mul", 4'b1100, 32'h0001_0001, 32'h0001_0001, 5'd0, 1'b1);
    check("mul value", {32'd0, result_o}, 64'h0002_0001);
    idle_after("mul");
    run_op("bad_code", 4'b0101, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 1'b0);
    run_op("b2b_add", 4'b0010, 32'd10, 32'd20, 5'd0, 1'b0);
    idle_after("b2b_add");

    // Reset during cycle 10 of a MUL aborts it silently
    ALUCtrl_i = 4'b1100; src1_i = 32'h0000_0003; src2_i = 32'h0000_0007; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    check("mul_abort busy_before", {63'd0, busy_o}, 64'd1);
    #2 rst_i = 1'b0;
    #1;
    check("abort busy", {63'd0, busy_o}, 64'd0);
    check("abort done", {63'd0, done_o}, 64'd0);
    check("abort result", {32'd0, result_o}, 64'd0);
    check("abort zero", {63'd0, zero_o}, 64'd0);
    check("abort err", {63'd0, err_o}, 64'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o !== 1'b0 || busy_o !== 1'b0) quiet = 1'b0;
    end
    check("abort no_done", {63'd0, quiet}, 64'd1);
    prev_res = '0;
    run_op("post_rst_add", 4'b0010, 32'd2, 32'd3, 5'd0, 1'b0);
    check("post_rst_add value", {32'd0, result_o}, 64'd5);
    idle_after("post_rst_add");

    // Randomized operations, some issued back-to-back
    for (int i = 0; i < 40; i++) begin
      int         idx;
      logic [3:0] op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      idx = $urandom_range(0, 10);
      op  = (idx == 10) ? 4'($urandom) : ops_tbl[idx];
      a   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
      b   = $urandom;
      run_op("rand", op, a, b, 5'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_after("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
